uart_ram_loader: RTL and testbench

- Sequences the RAM second write port (wEn2/addr2/dataIn2) from the UART receive byte stream.
- The processor arms the block through the memory map with a start address.
- Received bytes are packed little-endian into 32-bit words and written one word per RAM cycle at incrementing addresses.
- Bad transfers (timeout, abort, overflow) are flagged on a sticky error back to the memory map and the error LED.

---
 rtl/uart_ram_loader_pkg.sv | 17 +
 rtl/uart_word_packer.sv | 47 ++++
 rtl/uart_ram_loader.sv | 117 +++++++++++
 tb/tb_uart_ram_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ram_loader_pkg.sv
// Shared constants for the UART-to-RAM loader: FSM encoding, default address width
// and byte-lane geometry. The memory-map decode uses the same constants.
package uart_ram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int LANE_WIDTH         = 8;
  localparam int BYTE_LANES         = 4;
  localparam int WORD_WIDTH         = LANE_WIDTH * BYTE_LANES;
  localparam logic [1:0] LAST_LANE  = 2'd3;

endpackage

// File: rtl/uart_word_packer.sv
// Packs received bytes little-endian into a 32-bit word. The fourth byte is forwarded
// combinationally so the parent can capture the full word on the same edge.
module uart_word_packer
  import uart_ram_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rx_valid,
  input  logic [LANE_WIDTH-1:0] rx_byte,
  output logic [1:0]            byte_idx,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_ready
);

  localparam int BUF_WIDTH = LANE_WIDTH * (BYTE_LANES - 1);

  logic [1:0]           idx_reg;
  logic [BUF_WIDTH-1:0] buffer_reg;
  logic [BUF_WIDTH-1:0] buffer_next;

  assign byte_idx   = idx_reg;
  assign word_ready = rx_valid && !clear && (idx_reg == LAST_LANE);
  assign word       = {rx_byte, buffer_reg};

  // Only lanes 0..2 need storage; lane 3 is the byte arriving with word_ready.
  for (genvar gi = 0; gi < BYTE_LANES - 1; gi++) begin : g_lane
    assign buffer_next[gi*LANE_WIDTH +: LANE_WIDTH] =
      (clear || word_ready)              ? '0 :
      (rx_valid && idx_reg == 2'(gi))    ? rx_byte :
                                           buffer_reg[gi*LANE_WIDTH +: LANE_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg    <= '0;
      buffer_reg <= '0;
    end else begin
      buffer_reg <= buffer_next;
      if (clear)
        idx_reg <= '0;
      else if (rx_valid)
        idx_reg <= idx_reg + 2'd1;
    end
  end

endmodule

// File: rtl/uart_ram_loader.sv
// Drives RAM write port 2 from the UART byte stream: arm with a start address, pack
// bytes into words, write one word per cycle, flag timeout/abort/overflow on err.
module uart_ram_loader
  import uart_ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  stop,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  wEn2,
  output logic [ADDR_WIDTH-1:0] addr2,
  output logic [31:0]           dataIn2,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  err
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] next_addr_reg;
  logic [CNT_WIDTH-1:0]  tcnt_reg;

  logic        armed;
  logic        pack_valid;
  logic        pack_clear;
  logic        timeout_fire;
  logic        word_ready;
  logic [1:0]  byte_idx;
  logic [31:0] pack_word;

  uart_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .rx_valid   (pack_valid),
    .rx_byte    (rx_byte),
    .byte_idx   (byte_idx),
    .word       (pack_word),
    .word_ready (word_ready)
  );

  assign busy = (state_reg == ST_ARMED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Precedence: set_addr > stop > timeout/byte; a byte on the expiry cycle beats the timeout.
  always_comb begin
    state_next   = state_reg;
    armed        = (state_reg == ST_ARMED);
    pack_valid   = armed && rx_valid && !set_addr && !stop;
    timeout_fire = armed && !set_addr && !stop && !rx_valid && (byte_idx != 2'd0) &&
                   (tcnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    pack_clear   = set_addr || (armed && stop) || timeout_fire;
    if (set_addr)
      state_next = ST_ARMED;
    else if (armed && stop)
      state_next = ST_IDLE;
    else if (word_ready && (next_addr_reg == '1))
      state_next = ST_DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wEn2          <= 1'b0;
      addr2         <= '0;
      dataIn2       <= '0;
      words_written <= '0;
      err           <= 1'b0;
      next_addr_reg <= '0;
      tcnt_reg      <= '0;
    end else begin
      wEn2 <= 1'b0;
      if (set_addr) begin
        next_addr_reg <= start_addr;
        words_written <= '0;
        err           <= 1'b0;
        tcnt_reg      <= '0;
      end else if (armed && stop) begin
        if (byte_idx != 2'd0)
          err <= 1'b1;
        tcnt_reg <= '0;
      end else if (timeout_fire) begin
        err      <= 1'b1;
        tcnt_reg <= '0;
      end else if (armed) begin
        if (rx_valid)
          tcnt_reg <= '0;
        else if (byte_idx != 2'd0)
          tcnt_reg <= tcnt_reg + CNT_WIDTH'(1);
        if (word_ready) begin
          wEn2    <= 1'b1;
          addr2   <= next_addr_reg;
          dataIn2 <= pack_word;
          if (!words_written[ADDR_WIDTH])
            words_written <= words_written + (ADDR_WIDTH+1)'(1);
          // The top address is the last one written; the FSM moves to DONE instead of wrapping.
          if (next_addr_reg == '1)
            err <= 1'b1;
          else
            next_addr_reg <= next_addr_reg + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Randomized self-checking bench for uart_ram_loader against a byte-queue reference model.
module tb_uart_ram_loader;

  localparam int AW = 12;
  localparam int TO = 50;
  localparam int VW = 3 + (AW + 1) + AW + 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          set_addr = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          stop = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          wEn2;
  logic [AW-1:0] addr2;
  logic [31:0]   dataIn2;
  logic          busy;
  logic [AW:0]   words_written;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_ram_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(17)) dut (
    .clk(clk), .rst(rst), .set_addr(set_addr), .start_addr(start_addr), .stop(stop),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .wEn2(wEn2), .addr2(addr2), .dataIn2(dataIn2),
    .busy(busy), .words_written(words_written), .err(err)
  );

  // Reference model: armed/done flags, a queue of pending bytes, idle-cycle count.
  bit             m_armed, m_err, m_wen;
  int             m_ww, m_idle;
  logic [AW-1:0]  m_addr, m_addr2;
  logic [31:0]    m_data2;
  logic [7:0]     m_bytes[$];

  task automatic model_reset();
    m_armed = 0; m_err = 0; m_wen = 0; m_ww = 0; m_idle = 0;
    m_addr = '0; m_addr2 = '0; m_data2 = '0;
    m_bytes.delete();
  endtask

  task automatic model_edge(input bit v, input logic [7:0] b, input bit sa,
                            input logic [AW-1:0] a, input bit sp);
    m_wen = 0;
    if (sa) begin
      m_armed = 1; m_addr = a; m_ww = 0; m_err = 0; m_idle = 0;
      m_bytes.delete();
    end else if (m_armed && sp) begin
      if (m_bytes.size() != 0) m_err = 1;
      m_bytes.delete();
      m_armed = 0; m_idle = 0;
    end else if (m_armed) begin
      if (v) begin
        m_idle = 0;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
          m_wen   = 1;
          m_addr2 = m_addr;
          m_data2 = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_bytes.delete();
          if (m_ww < (1 << AW)) m_ww++;
          if (m_addr == {AW{1'b1}}) begin
            m_armed = 0; m_err = 1;
          end else begin
            m_addr = m_addr + 1'b1;
          end
        end
      end else if (m_bytes.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_bytes.delete(); m_err = 1; m_idle = 0;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {wEn2, busy, err, words_written, addr2, dataIn2};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_wen, m_armed, m_err, (AW+1)'(m_ww), m_addr2, m_data2};
  endfunction

  // One clock of stimulus, applied at the falling edge; outputs are read at the next one.
  task automatic step(input bit v, input logic [7:0] b, input bit sa,
                      input logic [AW-1:0] a, input bit sp);
    rx_valid = v; rx_byte = b; set_addr = sa; start_addr = a; stop = sp;
    @(posedge clk);
    model_edge(v, b, sa, a, sp);
    @(negedge clk);
    rx_valid = 0; set_addr = 0; stop = 0;
    if (m_wen) $display("write addr=%h data=%h", m_addr2, m_data2);
  endtask

  task automatic test_reset();
    logic [7:0] seq [4];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1;
    foreach (seq[i]) begin
      step(1, seq[i], 0, '0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle_bytes[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] seq [8];
    seq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    step(0, 0, 1, 12'h010, 0);
    foreach (seq[i]) begin
      step(1, seq[i], 0, '0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL basic[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({addr2, dataIn2, words_written, err, busy} !== {12'h011, 32'hDEADBEEF, 13'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_final got addr=%h data=%h ww=%0d err=%b busy=%b want 011 deadbeef 2 0 1",
               addr2, dataIn2, words_written, err, busy);
    end
    $display("test_basic done");
  endtask

  task automatic test_timeout();
    step(0, 0, 1, 12'h100, 0);
    step(1, 8'hA1, 0, '0, 0);
    step(1, 8'hA2, 0, '0, 0);
    for (int i = 0; i < TO + 4; i++) begin
      step(0, 0, 0, '0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_idle[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 8'hC0 + 8'(i), 0, '0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_resume[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({err, addr2, dataIn2, words_written} !== {1'b1, 12'h100, 32'hC3C2C1C0, 13'd1}) begin
      errors++;
      $display("FAIL timeout_final got err=%b addr=%h data=%h ww=%0d want 1 100 c3c2c1c0 1",
               err, addr2, dataIn2, words_written);
    end
    $display("test_timeout done");
  endtask

  task automatic test_overflow();
    int wr = 0;
    step(0, 0, 1, 12'hFFF, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h30 + i), 0, '0, 0);
      if (wEn2) wr++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL overflow[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({wr == 1, addr2, busy, err} !== {1'b1, 12'hFFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL overflow_final got writes=%0d addr=%h busy=%b err=%b want 1 fff 0 1",
               wr, addr2, busy, err);
    end
    $display("test_overflow done");
  endtask

  task automatic test_abort();
    step(0, 0, 1, 12'h020, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h55, 0, '0, 0);
    step(1, 8'h66, 0, '0, 1);
    checks++;
    if ({wEn2, busy, err} !== 3'b001 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL abort_stop got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 0, 1, 12'h030, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h77, 0, '0, 0);
    step(1, 8'h88, 1, 12'h040, 0);
    checks++;
    if ({wEn2, busy, err, words_written} !== {3'b010, 13'd0} || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL abort_setaddr got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) step(1, 8'h90 + 8'(i), 0, '0, 0);
    checks++;
    if ({addr2, dataIn2} !== {12'h040, 32'h93929190}) begin
      errors++; $display("FAIL abort_rearm got addr=%h data=%h want 040 93929190", addr2, dataIn2);
    end
    $display("test_abort done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit sa, sp, v;
      logic [AW-1:0] a;
      sa = ($urandom_range(0, 59) == 0);
      sp = ($urandom_range(0, 79) == 0);
      v  = ($urandom_range(0, 9) < 6);
      a  = ($urandom_range(0, 1) == 1) ? AW'(12'hFF0 + $urandom_range(0, 15)) : AW'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        for (int k = 0; k < TO + 3; k++) begin
          step(0, 0, 0, '0, 0);
          checks++;
          if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random_gap[%0d.%0d] got %h want %h", n, k, obs_vec(), exp_vec());
          end
        end
      end
      step(v, 8'($urandom), sa, a, sp);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d] got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 12'h050, 0);
    for (int i = 0; i < 3; i++) step(1, 8'hE0 + 8'(i), 0, '0, 0);
    rx_valid = 1; rx_byte = 8'hE3;
    #1 rst = 0;
    #2;
    checks++;
    if ({busy, err, words_written} !== {2'b00, 13'd0}) begin
      errors++; $display("FAIL async_immediate got busy=%b err=%b ww=%0d want 0 0 0", busy, err, words_written);
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 0;
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL async_state got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL async_after[%0d] got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_abort();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
